cpu_sequencer: RTL and testbench

Multi-cycle control FSM for the turtle CPU. It fetches each instruction through an instruction-memory handshake, loads the instruction register feeding the decoder, and gates the decoder's level enables into single-cycle write strobes. It also stalls on data-memory handshakes, updates the program counter and provides run/halt/single-step debug control. The block sits between the decoder, the register file, data memory, the program counter and the instruction-memory port.

---
 rtl/cpu_sequencer_pkg.sv | 12 +
 rtl/cpu_sequencer_mem_wait_timer.sv | 18 +
 rtl/cpu_sequencer.sv | 85 ++++++++
 tb/tb_cpu_sequencer.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/cpu_sequencer_pkg.sv
// cpu_sequencer_pkg: state encodings shared by the turtle CPU sequencer and its bench.
package cpu_sequencer_pkg;
   typedef enum logic [2:0] {
      STOPPED   = 3'd0,
      FETCH     = 3'd1,
      DECODE    = 3'd2,
      EXECUTE   = 3'd3,
      MEM       = 3'd4,
      WRITEBACK = 3'd5,
      BUS_ERROR = 3'd7
   } seq_state_e;
endpackage

// File: rtl/cpu_sequencer_mem_wait_timer.sv
// mem_wait_timer: 8-bit saturating wait counter; timeout is raised on the LIMIT-th waiting cycle.
module mem_wait_timer #(
   parameter int LIMIT = 15
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   input  logic enable,
   output logic timeout
);
   logic [7:0] count;
   always_ff @(posedge clk or posedge reset)
      if (reset) count <= '0;
      else if (clear) count <= '0;
      else if (enable && count != 8'hff) count <= count + 8'd1;
   // count holds the waiting cycles already elapsed, so the current one is count+1
   assign timeout = count >= 8'(LIMIT - 1);
endmodule

// File: rtl/cpu_sequencer.sv
// cpu_sequencer: multi-cycle fetch/decode/execute/mem/writeback control FSM with
// run/step debug control, bus-error timeout and retired-instruction counting.
module cpu_sequencer
   import cpu_sequencer_pkg::*;
#(
   parameter int MEM_TIMEOUT = 15,
   parameter int RETIRE_W    = 16
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                run,
   input  logic                step_req,
   output logic                imem_req,
   input  logic                imem_ack,
   output logic                ir_load,
   output logic                dmem_req,
   input  logic                dmem_ack,
   input  logic                dec_acc_write_enable,
   input  logic                dec_status_write_enable,
   input  logic                dec_data_memory_write_enable,
   input  logic                dec_data_memory_output_enable,
   input  logic                dec_jump_branch_select,
   input  logic                branch_taken,
   output logic                acc_write_strobe,
   output logic                status_write_strobe,
   output logic                dmem_write_strobe,
   output logic                dmem_read_enable,
   output logic                pc_increment,
   output logic                pc_load,
   output logic [2:0]          state,
   output logic                halted,
   output logic                bus_error,
   output logic [RETIRE_W-1:0] retired_count
);
   seq_state_e st, next;
   logic step, timeout, wb, take;

   mem_wait_timer #(.LIMIT(MEM_TIMEOUT)) timer (
      .clk(clk),
      .reset(reset),
      .clear(next != st),
      .enable(imem_req || dmem_req),
      .timeout(timeout)
   );

   always_comb begin
      next = st;
      case (st)
         STOPPED:   next = (run || step_req) ? FETCH : STOPPED;
         FETCH:     next = imem_ack ? DECODE : timeout ? BUS_ERROR : FETCH;
         DECODE:    next = EXECUTE;
         EXECUTE:   next = (dec_data_memory_write_enable || dec_data_memory_output_enable) ? MEM : WRITEBACK;
         MEM:       next = dmem_ack ? WRITEBACK : timeout ? BUS_ERROR : MEM;
         WRITEBACK: next = (run && !step) ? FETCH : STOPPED;
         default:   next = BUS_ERROR;
      endcase
   end

   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         st            <= STOPPED;
         step          <= 1'b0;
         bus_error     <= 1'b0;
         retired_count <= '0;
      end else begin
         st        <= next;
         bus_error <= bus_error || next == BUS_ERROR;
         step      <= st == STOPPED ? (!run && step_req) : st == WRITEBACK ? 1'b0 : step;
         if (wb) retired_count <= retired_count + RETIRE_W'(1);
      end

   assign wb                  = st == WRITEBACK;
   assign take                = dec_jump_branch_select && branch_taken;
   assign imem_req            = st == FETCH;
   assign ir_load             = imem_req && imem_ack;
   assign dmem_req            = st == MEM;
   assign dmem_write_strobe   = dmem_req && dmem_ack && dec_data_memory_write_enable;
   assign dmem_read_enable    = (dmem_req || wb) && dec_data_memory_output_enable;
   assign acc_write_strobe    = wb && dec_acc_write_enable;
   assign status_write_strobe = wb && dec_status_write_enable;
   assign pc_load             = wb && take;
   assign pc_increment        = wb && !take;
   assign state               = st;
   assign halted              = st == STOPPED || st == BUS_ERROR;
endmodule

// File: tb/tb_cpu_sequencer.sv
// tb_cpu_sequencer: scoreboard bench; each driven cycle queues its expected state,
// output bundle and retired count, which the negedge monitor pops and compares.
module tb_cpu_sequencer;
   import cpu_sequencer_pkg::*;

   localparam logic [10:0] IREQ = 11'h400, IRL = 11'h200, DREQ = 11'h100, DWS = 11'h080,
                           DRE = 11'h040, ACC = 11'h020, STS = 11'h010, PCI = 11'h008,
                           PCL = 11'h004, HLT = 11'h002, BER = 11'h001;

   typedef struct {
      logic [2:0]  s;
      logic [10:0] o;
      int          r;
   } exp_t;

   logic clk = 1'b0, reset = 1'b1, run = 1'b0, step_req = 1'b0, imem_ack = 1'b0, dmem_ack = 1'b0;
   logic acc_en = 1'b0, sts_en = 1'b0, we = 1'b0, oe = 1'b0, jmp = 1'b0, tk = 1'b0;
   logic imem_req, ir_load, dmem_req, acc_write_strobe, status_write_strobe, dmem_write_strobe;
   logic dmem_read_enable, pc_increment, pc_load, halted, bus_error;
   logic [2:0] state;
   logic [15:0] retired_count;
   logic [10:0] outs;
   exp_t q[$];
   int tests = 0, fails = 0, ret = 0, cycle = 0;

   always #5 clk = ~clk;

   cpu_sequencer #(.MEM_TIMEOUT(15), .RETIRE_W(16)) dut (
      .clk(clk),
      .reset(reset),
      .run(run),
      .step_req(step_req),
      .imem_req(imem_req),
      .imem_ack(imem_ack),
      .ir_load(ir_load),
      .dmem_req(dmem_req),
      .dmem_ack(dmem_ack),
      .dec_acc_write_enable(acc_en),
      .dec_status_write_enable(sts_en),
      .dec_data_memory_write_enable(we),
      .dec_data_memory_output_enable(oe),
      .dec_jump_branch_select(jmp),
      .branch_taken(tk),
      .acc_write_strobe(acc_write_strobe),
      .status_write_strobe(status_write_strobe),
      .dmem_write_strobe(dmem_write_strobe),
      .dmem_read_enable(dmem_read_enable),
      .pc_increment(pc_increment),
      .pc_load(pc_load),
      .state(state),
      .halted(halted),
      .bus_error(bus_error),
      .retired_count(retired_count)
   );

   assign outs = {imem_req, ir_load, dmem_req, dmem_write_strobe, dmem_read_enable,
                  acc_write_strobe, status_write_strobe, pc_increment, pc_load, halted, bus_error};

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s cycle %0d: got %0h expected %0h", tag, cycle, got, exp);
      end
   endtask

   always @(negedge clk)
      if (q.size() > 0) begin
         exp_t e;
         e = q.pop_front();
         check("state", 32'(state), 32'(e.s));
         check("outputs", 32'(outs), 32'(e.o));
         check("retired", 32'(retired_count), e.r);
      end

   task automatic cyc(input logic [2:0] s, input logic [10:0] o);
      q.push_back('{s, o, ret});
      @(posedge clk);
      #1 cycle++;
   endtask

   task automatic wb(input logic [10:0] o);
      cyc(WRITEBACK, o);
      ret++;
   endtask

   task automatic set_dec(input logic a, input logic s, input logic w, input logic r,
                          input logic j, input logic t);
      {acc_en, sts_en, we, oe, jmp, tk} = {a, s, w, r, j, t};
   endtask

   task automatic front();
      imem_ack = 1'b1;
      cyc(FETCH, IREQ | IRL);
      imem_ack = 1'b0;
      cyc(DECODE, 11'h0);
      cyc(EXECUTE, 11'h0);
   endtask

   initial begin
      repeat (2) @(posedge clk);
      #1 cyc(STOPPED, HLT);
      reset = 1'b0;
      cyc(STOPPED, HLT);
      // free-running ALU instructions
      set_dec(1, 1, 0, 0, 0, 0);
      run = 1'b1;
      cyc(STOPPED, HLT);
      repeat (2) begin
         front();
         wb(ACC | STS | PCI);
      end
      // LOAD with three cycles of dmem wait
      set_dec(1, 0, 0, 1, 0, 0);
      front();
      repeat (3) cyc(MEM, DREQ | DRE);
      dmem_ack = 1'b1;
      cyc(MEM, DREQ | DRE);
      dmem_ack = 1'b0;
      wb(ACC | PCI | DRE);
      // STORE acked on the second MEM cycle
      set_dec(0, 0, 1, 0, 0, 0);
      front();
      cyc(MEM, DREQ);
      dmem_ack = 1'b1;
      cyc(MEM, DREQ | DWS);
      dmem_ack = 1'b0;
      wb(PCI);
      // branch taken, then not taken while run drops mid-instruction
      set_dec(0, 0, 0, 0, 1, 1);
      front();
      wb(PCL);
      set_dec(0, 0, 0, 0, 1, 0);
      imem_ack = 1'b1;
      cyc(FETCH, IREQ | IRL);
      imem_ack = 1'b0;
      run = 1'b0;
      cyc(DECODE, 11'h0);
      cyc(EXECUTE, 11'h0);
      wb(PCI);
      cyc(STOPPED, HLT);
      // single step; a second step_req during EXECUTE is ignored
      set_dec(1, 1, 0, 0, 0, 0);
      step_req = 1'b1;
      cyc(STOPPED, HLT);
      step_req = 1'b0;
      imem_ack = 1'b1;
      cyc(FETCH, IREQ | IRL);
      imem_ack = 1'b0;
      cyc(DECODE, 11'h0);
      step_req = 1'b1;
      cyc(EXECUTE, 11'h0);
      step_req = 1'b0;
      wb(ACC | STS | PCI);
      cyc(STOPPED, HLT);
      cyc(STOPPED, HLT);
      // ack on the final allowed FETCH cycle beats the timeout
      run = 1'b1;
      cyc(STOPPED, HLT);
      repeat (14) cyc(FETCH, IREQ);
      front();
      wb(ACC | STS | PCI);
      // no ack at all: bus error after 15 FETCH cycles, then terminal
      repeat (15) cyc(FETCH, IREQ);
      cyc(BUS_ERROR, HLT | BER);
      {imem_ack, dmem_ack, step_req} = 3'b111;
      repeat (3) cyc(BUS_ERROR, HLT | BER);
      {imem_ack, dmem_ack, step_req} = 3'b000;
      // asynchronous reset away from any clock edge
      #2 reset = 1'b1;
      #1;
      check("async_reset_state", 32'(state), 32'(STOPPED));
      check("async_reset_bus_error", 32'(bus_error), 32'd0);
      check("async_reset_retired", 32'(retired_count), 32'd0);
      check("async_reset_outputs", 32'(outs), 32'(HLT));
      @(posedge clk);
      #1 reset = 1'b0;
      check("scoreboard_drained", 32'(q.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
